f1_start_controller: RTL and testbench

- Sequencer for the F1 start-lights FSM: issues its start trigger, generates the per-light step enable, and holds the lights fully on for a pseudo-random delay.
- Releases the lights with a single step pulse, then measures the driver's reaction time in clock cycles.
- Sits between the top-level buttons and the lights FSM. Replaces the free-running tick and delay blocks with one scheduler.

---
 rtl/f1_start_controller_if.sv | 26 ++
 rtl/f1_start_controller.sv | 131 +++++++++++++
 tb/tb_f1_start_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/f1_start_controller_if.sv
// Signal bundle between the F1 start controller, the top-level buttons and the lights FSM.
// The master modport is the controller's view of these signals; the slave modport is the view from the surrounding logic.
interface f1_start_controller_if #(
   parameter int RT_WIDTH = 16
);
   logic                start;
   logic                react;
   logic                cmd_seq;
   logic                cmd_delay;
   logic                trigger;
   logic                tick_en;
   logic                busy;
   logic                rt_valid;
   logic [RT_WIDTH-1:0] rt_count;
   logic                false_start;

   modport master (
      input  start, react, cmd_seq, cmd_delay,
      output trigger, tick_en, busy, rt_valid, rt_count, false_start
   );

   modport slave (
      output start, react, cmd_seq, cmd_delay,
      input  trigger, tick_en, busy, rt_valid, rt_count, false_start
   );
endinterface

// File: rtl/f1_start_controller.sv
// F1 start-lights scheduler: triggers the lights, paces each step, holds for a random delay, then times the reaction.
// Define F1_FALSE_START_EN to add false-start detection and the FLUSH state.
module f1_start_controller #(
   parameter int TICK_DIV   = 24,
   parameter int DELAY_UNIT = 16,
   parameter int RT_WIDTH   = 16
) (
   input logic                  clk,
   input logic                  rst,
   f1_start_controller_if.master bus
);
   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int UNIT_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [UNIT_W-1:0]   UNIT_LAST = UNIT_W'(DELAY_UNIT - 1);
   localparam logic [RT_WIDTH-1:0] RT_MAX    = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_LIGHTS, S_HOLD, S_RELEASE, S_TIMING, S_DONE
`ifdef F1_FALSE_START_EN
      , S_FLUSH
`endif
   } state_t;

   state_t              state, state_n;
   logic [TICK_W-1:0]   tick_cnt;
   logic [UNIT_W-1:0]   unit_sub;
   logic [6:0]          units_left;
   logic [6:0]          lfsr;
   logic [RT_WIDTH-1:0] rt_cnt;
   logic                react_q;
   logic                react_rise;
   logic                tick_en;

   assign react_rise = bus.react & ~react_q;

   // hold_units is reloaded from the LFSR on every LIGHTS cycle, so HOLD starts with the value present when cmd_delay rose.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         lfsr       <= 7'h01;
         react_q    <= 1'b0;
         tick_cnt   <= '0;
         unit_sub   <= '0;
         units_left <= '0;
         rt_cnt     <= '0;
      end else begin
         state   <= state_n;
         lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
         react_q <= bus.react;
         case (state)
            S_ARM: tick_cnt <= '0;
            S_LIGHTS: begin
               tick_cnt   <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
               units_left <= lfsr;
               unit_sub   <= '0;
            end
            S_HOLD: begin
               if (unit_sub == UNIT_LAST) begin
                  unit_sub   <= '0;
                  units_left <= units_left - 7'd1;
               end else begin
                  unit_sub <= unit_sub + 1'b1;
               end
            end
            S_RELEASE: rt_cnt <= '0;
            S_TIMING: begin
               if (!react_rise && rt_cnt != RT_MAX) rt_cnt <= rt_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // A react edge during LIGHTS or HOLD is assigned last so it overrides the normal transitions.
   always_comb begin
      state_n = state;
      tick_en = 1'b0;
      case (state)
         S_IDLE: if (bus.start) state_n = S_ARM;
         S_ARM: state_n = S_LIGHTS;
         S_LIGHTS: begin
            tick_en = (tick_cnt == TICK_LAST) && !bus.cmd_delay;
            if (bus.cmd_delay) state_n = S_HOLD;
`ifdef F1_FALSE_START_EN
            if (react_rise) state_n = S_FLUSH;
`endif
         end
         S_HOLD: begin
            if (unit_sub == UNIT_LAST && units_left == 7'd1) state_n = S_RELEASE;
`ifdef F1_FALSE_START_EN
            if (react_rise) state_n = S_FLUSH;
`endif
         end
         S_RELEASE: begin
            tick_en = 1'b1;
            state_n = S_TIMING;
         end
         S_TIMING: if (react_rise) state_n = S_DONE;
         S_DONE: if (bus.start) state_n = S_ARM;
`ifdef F1_FALSE_START_EN
         S_FLUSH: begin
            tick_en = bus.cmd_seq;
            if (!bus.cmd_seq) state_n = S_IDLE;
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

`ifdef F1_FALSE_START_EN
   logic false_start_q;

   // The flag survives FLUSH and IDLE so the driver can see it, and clears only when a new start is accepted.
   always_ff @(posedge clk) begin
      if (rst)                                                        false_start_q <= 1'b0;
      else if (state == S_IDLE && bus.start)                          false_start_q <= 1'b0;
      else if ((state == S_LIGHTS || state == S_HOLD) && react_rise)  false_start_q <= 1'b1;
   end

   assign bus.false_start = false_start_q;
`else
   assign bus.false_start = 1'b0;
`endif

   assign bus.trigger  = (state == S_ARM);
   assign bus.tick_en  = tick_en;
   assign bus.busy     = (state != S_IDLE) && (state != S_DONE);
   assign bus.rt_valid = (state == S_DONE);
   assign bus.rt_count = rt_cnt;
endmodule

// File: tb/tb_f1_start_controller.sv
// Randomized bench for f1_start_controller with a behavioural lights FSM and a sequence-level reference model.
// Expectations follow F1_FALSE_START_EN in the same way as the design.
module tb_f1_start_controller;
   localparam int TICK_DIV   = 4;
   localparam int DELAY_UNIT = 2;
   localparam int RT_W       = 4;
   localparam int RT_MAX     = (1 << RT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_compared   = 0;
   int   n_mismatched = 0;
   int   cyc          = 0;
   int   lfsr_seq [127];
   logic [3:0] lights;

   f1_start_controller_if #(.RT_WIDTH(RT_W)) bus ();

   f1_start_controller #(
      .TICK_DIV  (TICK_DIV),
      .DELAY_UNIT(DELAY_UNIT),
      .RT_WIDTH  (RT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Eight-light model: trigger lights the first lamp, each step adds one, a step with all eight lit turns them all off.
   always_ff @(posedge clk) begin
      if (rst)                 lights <= 4'd0;
      else if (bus.trigger)    lights <= 4'd1;
      else if (bus.tick_en)    lights <= (lights == 4'd8) ? 4'd0 : lights + 4'd1;
   end

   assign bus.cmd_seq   = (lights != 4'd0);
   assign bus.cmd_delay = (lights == 4'd8);

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int satCount(input int v);
      return (v > RT_MAX) ? RT_MAX : v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      bus.react = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_trigger", bus.trigger, 0);
      checkOutput("rst_tick_en", bus.tick_en, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_rt_valid", bus.rt_valid, 0);
      checkOutput("rst_false_start", bus.false_start, 0);
      checkOutput("rst_rt_count", bus.rt_count, 0);
      rst = 1'b0;
   endtask

   // One complete start sequence launched from IDLE or DONE.
   task automatic applyStimulus(input int react_delay, input bit fs_inject, input bit rst_in_hold);
      int gap, ticks, stray_trig, guard, captured, hold_cyc, ev_at, flush_ticks, late_ticks;
      bus.start = 1'b1;
      @(negedge clk);
      checkOutput("trigger_pulse", bus.trigger, 1);
      checkOutput("arm_rt_valid", bus.rt_valid, 0);
      checkOutput("arm_fs_clear", bus.false_start, 0);
      bus.start = 1'b0;

      gap = 0; ticks = 0; stray_trig = 0; guard = 0;
      while (!bus.cmd_delay && guard < 200) begin
         bus.start = 1'($urandom_range(0, 1));
         @(negedge clk);
         guard++; gap++;
         if (bus.trigger) stray_trig++;
         if (bus.tick_en) begin
            checkOutput("tick_gap", gap, TICK_DIV);
            gap = 0;
            ticks++;
         end
      end
      bus.start = 1'b0;
      checkOutput("lights_full", bus.cmd_delay, 1);
      checkOutput("step_ticks", ticks, 7);
      checkOutput("extra_trigger", stray_trig, 0);
      checkOutput("full_tick_en", bus.tick_en, 0);
      captured = lfsr_seq[cyc % 127];

      hold_cyc = 0; guard = 0;
      ev_at = (fs_inject || rst_in_hold) ? int'($urandom_range(1, captured * DELAY_UNIT)) : -1;
      while (guard < 400) begin
         bus.react = fs_inject && (hold_cyc == ev_at);
         if (rst_in_hold && hold_cyc == ev_at) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            checkOutput("hold_rst_busy", bus.busy, 0);
            checkOutput("hold_rst_tick_en", bus.tick_en, 0);
            checkOutput("hold_rst_rt_count", bus.rt_count, 0);
            rst = 1'b0;
            late_ticks = 0;
            repeat (captured * DELAY_UNIT + 10) begin
               @(negedge clk);
               if (bus.tick_en || bus.busy) late_ticks++;
            end
            checkOutput("hold_rst_quiet", late_ticks, 0);
            return;
         end
         @(negedge clk);
         guard++;
         if (bus.tick_en || !bus.busy) break;
         hold_cyc++;
      end
      bus.react = 1'b0;
      checkOutput("hold_bounded", guard < 400, 1);

`ifdef F1_FALSE_START_EN
      if (fs_inject) begin
         checkOutput("fs_flag", bus.false_start, 1);
         checkOutput("fs_rt_valid", bus.rt_valid, 0);
         flush_ticks = 0; guard = 0;
         while (bus.busy && guard < 50) begin
            checkOutput("flush_tick", bus.tick_en, lights != 4'd0);
            if (bus.tick_en) flush_ticks++;
            @(negedge clk);
            guard++;
         end
         checkOutput("flush_ticks", flush_ticks, 1);
         checkOutput("flush_idle", bus.busy, 0);
         checkOutput("fs_sticky", bus.false_start, 1);
         checkOutput("fs_no_result", bus.rt_valid, 0);
         return;
      end
`endif

      checkOutput("hold_len", hold_cyc, captured * DELAY_UNIT);
      checkOutput("release_tick", bus.tick_en, 1);
      checkOutput("no_false_start", bus.false_start, 0);

      for (int k = 1; k <= react_delay; k++) begin
         @(negedge clk);
         if (k == 1) checkOutput("lights_off", bus.cmd_seq, 0);
         checkOutput("rt_count_run", bus.rt_count, satCount(k - 1));
      end
      bus.react = 1'b1;
      @(negedge clk);
      checkOutput("done_rt_valid", bus.rt_valid, 1);
      checkOutput("done_rt_count", bus.rt_count, satCount(react_delay - 1));
      checkOutput("done_busy", bus.busy, 0);

      bus.react = 1'b0;
      @(negedge clk);
      bus.react = 1'b1;
      @(negedge clk);
      checkOutput("done_react_ignored", bus.rt_valid, 1);
      checkOutput("done_count_held", bus.rt_count, satCount(react_delay - 1));
      bus.react = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [6:0] v;
      bus.start = 1'b0;
      bus.react = 1'b0;
      v = 7'h01;
      for (int i = 0; i < 127; i++) begin
         lfsr_seq[i] = int'(v);
         v = {v[5:0], v[6] ^ v[5]};
      end

      doReset();
      applyStimulus(11, 1'b0, 1'b0);
      applyStimulus(31, 1'b0, 1'b0);
      applyStimulus(int'($urandom_range(2, 20)), 1'b1, 1'b0);
      applyStimulus(int'($urandom_range(2, 20)), 1'b0, 1'b0);
      applyStimulus(5, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(int'($urandom_range(2, 40)), 1'($urandom_range(0, 1)), 1'b0);
      end
      doReset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
